// File: rtl/all_things_pio_pkg.sv
// Shared register map for the all_things PIO blocks (LED output side and
// switch input side) and for generated software headers.
package all_things_pio_pkg;

  // Word addresses of the PIO register file.
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // STATUS register bit positions.
  localparam int STATUS_PHASE_BIT       = 0;
  localparam int STATUS_PERIOD_ZERO_BIT = 1;

  // Write-side decode of one bus cycle, kept together so the register
  // update logic and any bound checker see the same strobes.
  typedef struct packed {
    logic wr_data;
    logic wr_mask;
    logic wr_period;
    logic wr_status;
    logic wr_outset;
    logic wr_outclear;
  } pio_wr_dec_t;

  // Decode a qualified write (chipselect & write) at the given address.
  function automatic pio_wr_dec_t pio_decode_write(input logic       wr_en,
                                                   input logic [2:0] addr);
    pio_wr_dec_t dec;
    dec             = '0;
    dec.wr_data     = wr_en && (addr == ADDR_DATA);
    dec.wr_mask     = wr_en && (addr == ADDR_MASK);
    dec.wr_period   = wr_en && (addr == ADDR_PERIOD);
    dec.wr_status   = wr_en && (addr == ADDR_STATUS);
    dec.wr_outset   = wr_en && (addr == ADDR_OUTSET);
    dec.wr_outclear = wr_en && (addr == ADDR_OUTCLEAR);
    return dec;
  endfunction

endpackage

// File: rtl/all_things_blink_div.sv
// Blink divider: counts half-periods of `period` clocks and flips `phase`
// at the end of each one. period == 0 parks the engine at cnt=0, phase=0.
// `restart` forces cnt=0, phase=0 on that edge and wins over a terminal
// count arriving in the same cycle.
module all_things_blink_div #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] period,
  input  logic             restart,
  output logic             phase,
  output logic [DIV_W-1:0] cnt_dbg
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             phase_q;
  logic             phase_d;
  logic             terminal;

  // The counter wraps when it reaches period-1, so a half-period is
  // exactly `period` clocks; period==1 therefore toggles every clock.
  assign terminal = (cnt_q == (period - {{(DIV_W-1){1'b0}}, 1'b1}));

  // Next-state: restart/off override, then wrap-and-toggle or increment.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart || (period == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (terminal) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter and phase registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase   = phase_q;
  assign cnt_dbg = cnt_q;

endmodule

// File: rtl/all_things_led_pio.sv
// LED output PIO: software data register with atomic set/clear aliases,
// blink mask and period registers, and a blink engine that blanks masked
// outputs during phase 1.
//
// Bus handshake: a write is accepted on any rising edge where
// chipselect && write is high (no wait states, always ready). Reads need no
// strobe: readdata is re-registered every clock from the register selected
// by `address`, so it is valid one edge after the address is presented.
module all_things_led_pio
  import all_things_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          DIV_W       = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] period_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;

  logic             wr_en;
  pio_wr_dec_t      wr_dec;
  logic             blink_restart;
  logic             phase;
  logic [DIV_W-1:0] blink_cnt;
  logic [WIDTH-1:0] wdata_w;

  // Bits of writedata above the register widths are deliberately dropped;
  // the counter value is only observed by debug/bind logic.
  logic unused_inputs;
  assign unused_inputs = ^{writedata, blink_cnt};

  assign wr_en   = chipselect && write;
  assign wr_dec  = pio_decode_write(wr_en, address);
  assign wdata_w = writedata[WIDTH-1:0];

  // Any write to PERIOD or STATUS realigns the blink to the start of phase 0.
  assign blink_restart = wr_dec.wr_period || wr_dec.wr_status;

  all_things_blink_div #(
    .DIV_W (DIV_W)
  ) u_blink_div (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_q),
    .restart (blink_restart),
    .phase   (phase),
    .cnt_dbg (blink_cnt)
  );

  // Register file update: plain writes and read-modify-write aliases.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_dec.wr_data) begin
      data_d = wdata_w;
    end
    if (wr_dec.wr_outset) begin
      data_d = data_q | wdata_w;
    end
    if (wr_dec.wr_outclear) begin
      data_d = data_q & ~wdata_w;
    end
    if (wr_dec.wr_mask) begin
      mask_d = wdata_w;
    end
    if (wr_dec.wr_period) begin
      period_d = writedata[DIV_W-1:0];
    end
  end

  // Read mux: zero-extended register selected by address; aliases and
  // reserved words read as 0.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:   readdata_d[WIDTH-1:0] = data_q;
      ADDR_MASK:   readdata_d[WIDTH-1:0] = mask_q;
      ADDR_PERIOD: readdata_d[DIV_W-1:0] = period_q;
      ADDR_STATUS: begin
        readdata_d[STATUS_PHASE_BIT]       = phase;
        readdata_d[STATUS_PERIOD_ZERO_BIT] = (period_q == '0);
      end
      default:     readdata_d = '0;
    endcase
  end

  // Register state with synchronous active-low reset; a write presented
  // during reset is discarded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE[WIDTH-1:0];
      mask_q     <= '0;
      period_q   <= '0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      period_q   <= period_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q & ~(mask_q & {WIDTH{phase}});

endmodule

// File: tb/tb_all_things_led_pio.sv
// Self-checking bench for all_things_led_pio (WIDTH=8, RESET_VALUE=8'hA5).
module tb_all_things_led_pio;

  localparam int WIDTH = 8;
  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       address = 3'd0;
  logic             chipselect = 1'b0;
  logic             write = 1'b0;
  logic [31:0]      writedata = 32'h0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] rd;
  int          tests_run = 0;
  int          tests_failed = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  all_things_led_pio #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (32'h0000_00A5),
    .DIV_W       (DIV_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write      = 1'b1;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b0;
    write      = 1'b0;
    address    = a;
    tick();
    d = readdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    exp_q.push_back(32'h0000_00A5);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_out_port: got %h expected %h", out_port, exp_v[7:0]);
    end
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (readdata !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_readdata: got %h expected %h", readdata, exp_v);
    end
    reset_n = 1'b1;
    exp_q.push_back(32'h0000_0002);
    do_read(3'd3, rd);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_status: got %h expected %h", rd, exp_v);
    end
    exp_q.push_back(32'h0000_00A5);
    do_read(3'd0, rd);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_data_read: got %h expected %h", rd, exp_v);
    end
  endtask

  task automatic test_data_write();
    exp_q.push_back(32'h0000_003C);
    do_write(3'd0, 32'hFFFF_FF3C);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL data_out_port: got %h expected %h", out_port, exp_v[7:0]);
    end
    exp_q.push_back(32'h0000_003C);
    do_read(3'd0, rd);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd !== exp_v) begin
      tests_failed++;
      $display("FAIL data_read: got %h expected %h", rd, exp_v);
    end
    // write strobe without chipselect must be ignored
    address    = 3'd0;
    writedata  = 32'h0;
    chipselect = 1'b0;
    write      = 1'b1;
    exp_q.push_back(32'h0000_003C);
    tick();
    write = 1'b0;
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL no_cs_write: got %h expected %h", out_port, exp_v[7:0]);
    end
  endtask

  task automatic test_set_clear();
    do_write(3'd0, 32'h0000_000F);
    exp_q.push_back(32'h0000_00FF);
    do_write(3'd4, 32'h0000_00F0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL outset: got %h expected %h", out_port, exp_v[7:0]);
    end
    exp_q.push_back(32'h0000_007E);
    do_write(3'd5, 32'h0000_0081);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL outclear: got %h expected %h", out_port, exp_v[7:0]);
    end
    for (int a = 4; a <= 7; a++) begin
      if (a >= 6) do_write(a[2:0], 32'hFFFF_FFFF);
      exp_q.push_back(32'h0);
      do_read(a[2:0], rd);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (rd !== exp_v) begin
        tests_failed++;
        $display("FAIL alias_read_%0d: got %h expected %h", a, rd, exp_v);
      end
    end
    // back-to-back set then clear of bit 7
    exp_q.push_back(32'h0000_00FE);
    do_write(3'd4, 32'h0000_0080);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL b2b_set: got %h expected %h", out_port, exp_v[7:0]);
    end
    exp_q.push_back(32'h0000_007E);
    do_write(3'd5, 32'h0000_0080);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL b2b_clear: got %h expected %h", out_port, exp_v[7:0]);
    end
  endtask

  task automatic test_blink();
    do_write(3'd0, 32'h0000_00FF);
    do_write(3'd1, 32'hFFFF_FF0F);
    do_write(3'd2, 32'd4);
    address = 3'd3;
    exp_q.push_back(32'h0000_00FF);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL blink_start: got %h expected %h", out_port, exp_v[7:0]);
    end
    for (int k = 1; k <= 20; k++) begin
      exp_q.push_back((((k / 4) % 2) == 1) ? 32'h0000_00F0 : 32'h0000_00FF);
      exp_q.push_back((((k - 1) / 4) % 2 == 1) ? 32'h1 : 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if ({24'h0, out_port} !== exp_v) begin
        tests_failed++;
        $display("FAIL blink_out_k%0d: got %h expected %h", k, out_port, exp_v[7:0]);
      end
      exp_v = exp_q.pop_front();
      tests_run++;
      if (readdata !== exp_v) begin
        tests_failed++;
        $display("FAIL blink_status_k%0d: got %h expected %h", k, readdata, exp_v);
      end
    end
    exp_q.push_back(32'h0000_000F);
    do_read(3'd1, rd);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd !== exp_v) begin
      tests_failed++;
      $display("FAIL mask_read: got %h expected %h", rd, exp_v);
    end
    exp_q.push_back(32'd4);
    do_read(3'd2, rd);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd !== exp_v) begin
      tests_failed++;
      $display("FAIL period_read: got %h expected %h", rd, exp_v);
    end
  endtask

  task automatic test_restart();
    do_write(3'd2, 32'd4);
    for (int k = 1; k <= 5; k++) tick();
    exp_q.push_back(32'h0000_00F0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL restart_pre: got %h expected %h", out_port, exp_v[7:0]);
    end
    // mid-phase-1 restart
    exp_q.push_back(32'h0000_00FF);
    do_write(3'd3, 32'hDEAD_BEEF);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL restart_mid: got %h expected %h", out_port, exp_v[7:0]);
    end
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(32'h0000_00FF);
      tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if ({24'h0, out_port} !== exp_v) begin
        tests_failed++;
        $display("FAIL restart_hold_k%0d: got %h expected %h", k, out_port, exp_v[7:0]);
      end
    end
    // restart in the same cycle as terminal count: no toggle
    exp_q.push_back(32'h0000_00FF);
    do_write(3'd3, 32'h0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL restart_terminal: got %h expected %h", out_port, exp_v[7:0]);
    end
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back((k == 4) ? 32'h0000_00F0 : 32'h0000_00FF);
      tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if ({24'h0, out_port} !== exp_v) begin
        tests_failed++;
        $display("FAIL restart_next_k%0d: got %h expected %h", k, out_port, exp_v[7:0]);
      end
    end
    // PERIOD=0 stops blinking
    do_write(3'd2, 32'd0);
    for (int k = 0; k <= 5; k++) begin
      exp_q.push_back(32'h0000_00FF);
      if (k > 0) tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if ({24'h0, out_port} !== exp_v) begin
        tests_failed++;
        $display("FAIL blink_off_k%0d: got %h expected %h", k, out_port, exp_v[7:0]);
      end
    end
    exp_q.push_back(32'h0000_0002);
    do_read(3'd3, rd);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (rd !== exp_v) begin
      tests_failed++;
      $display("FAIL blink_off_status: got %h expected %h", rd, exp_v);
    end
  endtask

  task automatic test_reset_mid_blink();
    do_write(3'd2, 32'd1);
    for (int k = 0; k <= 3; k++) begin
      exp_q.push_back(((k % 2) == 1) ? 32'h0000_00F0 : 32'h0000_00FF);
      if (k > 0) tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if ({24'h0, out_port} !== exp_v) begin
        tests_failed++;
        $display("FAIL p1_blink_k%0d: got %h expected %h", k, out_port, exp_v[7:0]);
      end
    end
    // one-cycle reset with a competing DATA write that must be dropped
    reset_n    = 1'b0;
    address    = 3'd0;
    writedata  = 32'h0;
    chipselect = 1'b1;
    write      = 1'b1;
    tick();
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write      = 1'b0;
    exp_q.push_back(32'h0000_00A5);
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({24'h0, out_port} !== exp_v) begin
      tests_failed++;
      $display("FAIL midreset_out: got %h expected %h", out_port, exp_v[7:0]);
    end
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(32'h0000_00A5);
      tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if ({24'h0, out_port} !== exp_v) begin
        tests_failed++;
        $display("FAIL midreset_hold_k%0d: got %h expected %h", k, out_port, exp_v[7:0]);
      end
    end
    for (int a = 1; a <= 3; a++) begin
      exp_q.push_back((a == 3) ? 32'h0000_0002 : 32'h0);
      do_read(a[2:0], rd);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (rd !== exp_v) begin
        tests_failed++;
        $display("FAIL midreset_read_%0d: got %h expected %h", a, rd, exp_v);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_data_write();
    test_set_clear();
    test_blink();
    test_restart();
    test_reset_mid_blink();
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
